dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request/response, byte/half/word access, wait states.
// Optional macro DMEM_CLR_ON_RST_EN: zero the whole memory after reset before accepting requests.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
`ifdef DMEM_CLR_ON_RST_EN
  localparam logic [1:0] S_CLEAR = 2'd3;
  localparam logic [1:0] S_RST   = S_CLEAR;
  logic [ADDR_W-1:0] clr_idx;
`else
  localparam logic [1:0] S_RST   = S_IDLE;
`endif

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] widx;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;
  logic              acc_err;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic              commit;

  assign req_ready = (state == S_IDLE);

  always_comb begin
    widx    = addr_q[ADDR_W+1:2];
    rd_word = mem[widx];
    case (addr_q[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   load_data = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // Fault decode on the captured request: bad size, misalignment, address beyond the array.
  always_comb begin
    case (size_q)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = addr_q[0];
      2'b10:   acc_err = (addr_q[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
    if ((addr_q >> (ADDR_W + 2)) != 32'd0) acc_err = 1'b1;
  end

  always_comb begin
    case (size_q)
      2'b00: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_q;
      end
    endcase
    commit = (state == S_WAIT) && (cnt == 4'd0) && we_q && !acc_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RST;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
`ifdef DMEM_CLR_ON_RST_EN
      clr_idx   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          we_q    <= req_we;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt     <= 4'(WAIT_CYCLES);
          state   <= S_WAIT;
        end
        S_WAIT: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= acc_err;
          rsp_rdata <= (acc_err || we_q) ? 32'd0 : load_data;
          state     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
`ifdef DMEM_CLR_ON_RST_EN
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array write port; stores land on the same edge the response is raised.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLR_ON_RST_EN
    if (!rst && state == S_CLEAR) begin
      mem[clr_idx] <= 32'd0;
    end else if (!rst && commit) begin
`else
    if (!rst && commit) begin
`endif
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: reference memory model, latency, hold, fault and reset checks.
module tb_dmem_responder;
`ifdef DMEM_CLR_ON_RST_EN
  localparam int AW = 4;
`else
  localparam int AW = 10;
`endif
  localparam int WC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mdl [int];

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    int n;
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    n = 0;
    while (!req_ready && n < 5000) begin
      @(posedge clk); #1; n++;
    end
`ifdef DMEM_CLR_ON_RST_EN
    check("clear_len", 32'(n), 32'(1 << AW));
    mdl.delete();
    for (int i = 0; i < (1 << AW); i++) mdl[i] = 32'd0;
`else
    check("ready_after_rst", 32'(n), 32'd0);
`endif
  endtask

  task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk); n++;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
    req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic err;
    logic [31:0] rd, w, sh, held;
    logic [32:0] e;
    int n, k;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
          || ((a >> (AW + 2)) != 32'd0);
    rd = 32'd0;
    k  = int'(a >> 2);
    if (!err) begin
      w = mdl.exists(k) ? mdl[k] : 32'd0;
      if (we) begin
        case (sz)
          2'b00:   w[int'(a[1:0]) * 8 +: 8] = wd[7:0];
          2'b01:   w[int'(a[1]) * 16 +: 16] = wd[15:0];
          default: w = wd;
        endcase
        mdl[k] = w;
      end else begin
        sh = w >> (int'(a[1:0]) * 8);
        case (sz)
          2'b00:   rd = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
          2'b01:   rd = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
          default: rd = w;
        endcase
      end
    end
    exp_q.push_back({err, rd});
    drive_req(we, sz, uns, a, wd);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(WC + 1));
    held = rsp_rdata;
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, held);
      check({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    e = exp_q.pop_front();
    check({tag, "_rdata"}, rsp_rdata, e[31:0]);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e[32]});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    do_reset(3);
`ifdef DMEM_CLR_ON_RST_EN
    for (int i = 0; i < (1 << AW); i++) xact("clr_lw", 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'd0, 0);
`endif
    xact("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    xact("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0);
    xact("sw14", 1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, 0);
    xact("sb15", 1'b1, 2'b00, 1'b0, 32'h15, 32'h123456AB, 0);
    xact("lw14", 1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 0);
    xact("lb15", 1'b0, 2'b00, 1'b0, 32'h15, 32'd0, 0);
    xact("lbu15", 1'b0, 2'b00, 1'b1, 32'h15, 32'd0, 0);
    xact("lh14", 1'b0, 2'b01, 1'b0, 32'h14, 32'd0, 0);
    xact("sw12_mis", 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 0);
    xact("lw10_again", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0);
    xact("lw_oor", 1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'd0, 0);
    xact("size3", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 0);
    xact("lh13_mis", 1'b0, 2'b01, 1'b0, 32'h13, 32'd0, 0);
    xact("sw18", 1'b1, 2'b10, 1'b0, 32'h18, 32'h0000_0000, 0);
    xact("sh1a", 1'b1, 2'b01, 1'b0, 32'h1A, 32'hCAFEBEEF, 0);
    xact("lhu1a", 1'b0, 2'b01, 1'b1, 32'h1A, 32'd0, 0);
    xact("lh1a", 1'b0, 2'b01, 1'b0, 32'h1A, 32'd0, 0);
    xact("lw18", 1'b0, 2'b10, 1'b0, 32'h18, 32'd0, 0);
    xact("hold", 1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 4);

    // Store dropped by a reset during its wait states.
    xact("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0BAD_F00D, 0);
    drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h5555AAAA);
    @(posedge clk);
    do_reset(1);
    seen = 0;
    repeat (WC + 3) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("wait_rst_no_rsp", 32'(seen), 32'd0);
    xact("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 0);

    // Pending response discarded by reset.
    drive_req(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    repeat (WC + 2) @(posedge clk);
    #1;
    check("resp_pending", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("resp_rst_drop", {31'd0, rsp_valid}, 32'd0);
    do_reset(1);
    xact("lw20_post", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
